// File: rtl/ram_unit_bem.sv
// Parametrised RAM with per-lane write masking, a registered read port with a valid flag,
// write-first forwarding on same-address collisions and a hardware clear sweep.
module ram_unit_bem #(
  parameter int A            = 8,
  parameter int D            = 8,
  parameter int LANES        = 1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [A-1:0]     raddr,
  output logic [D-1:0]     rdata,
  output logic             rvalid,
  input  logic             we,
  input  logic [A-1:0]     waddr,
  input  logic [D-1:0]     wdata,
  input  logic [LANES-1:0] wmask,
  input  logic             clr,
  output logic             busy
);

  localparam int W = D / LANES;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [A-1:0]   cnt;
  logic           sweep_done;
  logic [D-1:0]   merged;
  logic [D-1:0]   mem [2**A];

  assign busy       = (state == CLEAR);
  assign sweep_done = (cnt == {A{1'b1}});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (sweep_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt is held at zero while idle, so a clr request always starts the sweep at address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RST ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + {{(A-1){1'b0}}, 1'b1};
      else                cnt <= '0;
    end
  end

  // Write-first: a same-address write replaces its masked lanes in the word being read
  always_comb begin
    merged = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) merged[i*W +: W] = wdata[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (!busy && re) begin
      rdata  <= merged;
      rvalid <= 1'b1;
    end else begin
      rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[cnt] <= '0;
      end else if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) mem[waddr][i*W +: W] <= wdata[i*W +: W];
        end
      end
    end
  end

endmodule
